// File: rtl/chain_score_max_pkg.sv
// Shared constants for the chain-score max reducer.
// FSM encoding, predecessor sentinel and default widths.
package chain_score_max_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int IDX_W_DEF  = 16;

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  localparam logic [63:0] NO_PRED = '1;

endpackage

// File: rtl/chain_score_max_sat_add.sv
// Signed adder clamped to the W-bit range.
// The sum is formed one bit wider to catch overflow.
module sat_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  logic [W:0] sum;

  assign sum = {a_i[W-1], a_i} + {b_i[W-1], b_i};

  always_comb begin
    y_o = sum[W-1:0];
    if (sum[W] != sum[W-1]) begin
      y_o = sum[W] ? {1'b1, {(W-1){1'b0}}}
                   : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/chain_score_max.sv
// Per-anchor reducer: best of anc_w and f[j]+score(j,i).
// One register stage (P1) feeds the accumulator.
module chain_score_max
  import chain_score_max_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cand_valid,
  output logic              cand_ready,
  input  logic              cand_first,
  input  logic              cand_last,
  input  logic              cand_skip,
  input  logic [DATA_W-1:0] anc_w,
  input  logic [IDX_W-1:0]  cand_idx,
  input  logic [DATA_W-1:0] cand_f,
  input  logic [DATA_W-1:0] cand_score,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_f,
  output logic [IDX_W-1:0]  out_pred,
  output logic [IDX_W-1:0]  out_cnt,
  output logic              err
);

  localparam logic [IDX_W-1:0] NoPred =
    NO_PRED[IDX_W-1:0];

  logic [1:0]        state_q, state_d;
  logic              rdy_q;
  logic              open_q, open_d;
  logic              err_q, err_d;
  logic              take, load;
  logic [DATA_W-1:0] sum_w;

  logic              p1_vld_q, p1_first_q;
  logic              p1_skip_q;
  logic [IDX_W-1:0]  p1_idx_q;
  logic [DATA_W-1:0] p1_sum_q, p1_anc_q;

  logic [DATA_W-1:0] acc_f_q, acc_f_d;
  logic [IDX_W-1:0]  acc_pred_q, acc_pred_d;
  logic [IDX_W-1:0]  acc_cnt_q, acc_cnt_d;

  logic [DATA_W-1:0] out_f_q;
  logic [IDX_W-1:0]  out_pred_q, out_cnt_q;

  sat_add #(.W(DATA_W)) u_add (
    .a_i (cand_f),
    .b_i (cand_score),
    .y_o (sum_w)
  );

  assign cand_ready = rdy_q && (state_q == ST_ACC);
  assign out_valid  = (state_q == ST_OUT);
  assign out_f      = out_f_q;
  assign out_pred   = out_pred_q;
  assign out_cnt    = out_cnt_q;
  assign err        = err_q;

  assign take = cand_valid && cand_ready;
  // orphan non-first beats never reach P1
  assign load = take && (cand_first || open_q);

  always_comb begin
    state_d = state_q;
    open_d  = open_q;
    err_d   = err_q;
    unique case (1'b1)
      state_q == ST_ACC:
        if (load && cand_last) state_d = ST_DRAIN;
      state_q == ST_DRAIN:
        state_d = ST_OUT;
      state_q == ST_OUT:
        if (out_ready) state_d = ST_ACC;
      default:
        state_d = ST_ACC;
    endcase
    if (take) begin
      if (cand_first && open_q)   err_d = 1'b1;
      if (!cand_first && !open_q) err_d = 1'b1;
    end
    if (load) open_d = !cand_last;
  end

  always_comb begin
    acc_f_d    = acc_f_q;
    acc_pred_d = acc_pred_q;
    acc_cnt_d  = acc_cnt_q;
    if (p1_vld_q) begin
      if (p1_first_q) begin
        acc_f_d    = p1_anc_q;
        acc_pred_d = NoPred;
        acc_cnt_d  = '0;
      end
      if (!p1_skip_q) begin
        if (acc_cnt_d != NoPred)
          acc_cnt_d = acc_cnt_d + 1'b1;
        // strict compare keeps the earlier winner on ties
        if ($signed(p1_sum_q) > $signed(acc_f_d)) begin
          acc_f_d    = p1_sum_q;
          acc_pred_d = p1_idx_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_ACC;
      rdy_q      <= 1'b0;
      open_q     <= 1'b0;
      err_q      <= 1'b0;
      p1_vld_q   <= 1'b0;
      p1_first_q <= 1'b0;
      p1_skip_q  <= 1'b0;
      p1_idx_q   <= '0;
      p1_sum_q   <= '0;
      p1_anc_q   <= '0;
      acc_f_q    <= '0;
      acc_pred_q <= NoPred;
      acc_cnt_q  <= '0;
      out_f_q    <= '0;
      out_pred_q <= NoPred;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= 1'b1;
      open_q     <= open_d;
      err_q      <= err_d;
      p1_vld_q   <= load;
      if (load) begin
        p1_first_q <= cand_first;
        p1_skip_q  <= cand_skip;
        p1_idx_q   <= cand_idx;
        p1_sum_q   <= sum_w;
        p1_anc_q   <= anc_w;
      end
      acc_f_q    <= acc_f_d;
      acc_pred_q <= acc_pred_d;
      acc_cnt_q  <= acc_cnt_d;
      if (state_q == ST_DRAIN) begin
        out_f_q    <= acc_f_d;
        out_pred_q <= acc_pred_d;
        out_cnt_q  <= acc_cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_chain_score_max.sv
// Directed bench for chain_score_max.
// Expected values are hand-computed per step.
module tb_chain_score_max;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cand_valid = 1'b0;
  logic        cand_ready;
  logic        cand_first = 1'b0;
  logic        cand_last = 1'b0;
  logic        cand_skip = 1'b0;
  logic [31:0] anc_w = '0;
  logic [15:0] cand_idx = '0;
  logic [31:0] cand_f = '0;
  logic [31:0] cand_score = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_f;
  logic [15:0] out_pred;
  logic [15:0] out_cnt;
  logic        err;

  int vec = 0;
  int miss = 0;

  chain_score_max dut (
    .clk        (clk),
    .reset      (reset),
    .cand_valid (cand_valid),
    .cand_ready (cand_ready),
    .cand_first (cand_first),
    .cand_last  (cand_last),
    .cand_skip  (cand_skip),
    .anc_w      (anc_w),
    .cand_idx   (cand_idx),
    .cand_f     (cand_f),
    .cand_score (cand_score),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_f      (out_f),
    .out_pred   (out_pred),
    .out_cnt    (out_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic beat(input logic        first,
                      input logic        last,
                      input logic        skip,
                      input logic [31:0] anc,
                      input logic [15:0] idx,
                      input logic [31:0] f,
                      input logic [31:0] s);
    cand_valid = 1'b1;
    cand_first = first;
    cand_last  = last;
    cand_skip  = skip;
    anc_w      = anc;
    cand_idx   = idx;
    cand_f     = f;
    cand_score = s;
    @(posedge clk);
    #1;
    cand_valid = 1'b0;
    cand_first = 1'b0;
    cand_last  = 1'b0;
    cand_skip  = 1'b0;
  endtask

  // called #1 after the edge accepting the last beat
  task automatic result(input string       tag,
                        input logic [31:0] ef,
                        input logic [15:0] ep,
                        input logic [15:0] ec);
    chk({tag, "_drain_ovld"}, out_valid, 0);
    chk({tag, "_drain_rdy"}, cand_ready, 0);
    @(posedge clk);
    #1;
    chk({tag, "_ovld"}, out_valid, 1);
    chk({tag, "_f"}, out_f, ef);
    chk({tag, "_pred"}, out_pred, ep);
    chk({tag, "_cnt"}, out_cnt, ec);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_done_ovld"}, out_valid, 0);
    chk({tag, "_done_rdy"}, cand_ready, 1);
  endtask

  initial begin
    #22;
    chk("rst_ovld", out_valid, 0);
    chk("rst_f", out_f, 0);
    chk("rst_pred", out_pred, 16'hFFFF);
    chk("rst_cnt", out_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_rdy", cand_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_rdy", cand_ready, 1);

    beat(1, 0, 0, 15, 3, 10, 4);
    beat(0, 0, 0, 0, 7, 20, -32'sd2);
    beat(0, 1, 0, 0, 9, 30, -32'sd12);
    result("grp3", 18, 7, 3);

    beat(1, 1, 1, 5, 4, 99, 99);
    result("skip1", 5, 16'hFFFF, 0);

    beat(1, 0, 0, 0, 2, 5, 5);
    beat(0, 1, 0, 0, 4, 8, 2);
    result("tie_j", 10, 2, 2);

    beat(1, 1, 0, 10, 1, 6, 4);
    result("tie_anc", 10, 16'hFFFF, 1);

    beat(1, 1, 0, 0, 5, 32'h7FFFFFF0, 32'h100);
    result("sat_hi", 32'h7FFFFFFF, 5, 1);

    beat(1, 1, 0, 0, 6, 32'h80000010, -32'sh100);
    result("sat_lo", 0, 16'hFFFF, 1);

    beat(1, 1, 0, 1, 2, 3, 4);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_ovld", out_valid, 1);
      chk("hold_f", out_f, 7);
      chk("hold_pred", out_pred, 2);
      chk("hold_cnt", out_cnt, 1);
      chk("hold_rdy", cand_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold_done", out_valid, 0);

    chk("err_pre", err, 0);
    beat(1, 0, 0, 0, 1, 100, 0);
    chk("err_open", err, 0);
    beat(1, 0, 0, 2, 6, 3, 3);
    chk("err_restart", err, 1);
    beat(0, 1, 0, 0, 8, 1, 1);
    result("restart", 6, 6, 2);

    beat(1, 1, 0, 3, 1, 50, 0);
    reset = 1'b0;
    #1;
    chk("rd_ovld", out_valid, 0);
    chk("rd_err", err, 0);
    chk("rd_pred", out_pred, 16'hFFFF);
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rd_no_out", out_valid, 0);
    end
    chk("rd_rdy", cand_ready, 1);
    beat(1, 0, 0, 4, 2, 1, 1);
    beat(0, 1, 0, 0, 3, 2, 3);
    result("post_rst", 5, 3, 2);

    beat(0, 1, 0, 0, 9, 1000, 0);
    chk("orph_err", err, 1);
    chk("orph_rdy", cand_ready, 1);
    @(posedge clk);
    #1;
    chk("orph_ovld", out_valid, 0);
    chk("orph_rdy2", cand_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule
